// File: rtl/uart_byte_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo_pkg
// Shared constants and types for the UART echo-path byte FIFO.
//   - BYTE_W               : width of a UART byte (8)
//   - DEFAULT_DEPTH_LOG2   : default log2 of the FIFO depth (16 entries)
//   - DEFAULT_BUSY_TIMEOUT : default cycles to wait for tx_busy to rise
//   - drain_state_t        : drain FSM state encoding
// -----------------------------------------------------------------------------
package uart_byte_fifo_pkg;

  localparam int BYTE_W               = 8;
  localparam int DEFAULT_DEPTH_LOG2   = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } drain_state_t;

endpackage

// File: rtl/uart_byte_fifo_fifo_mem_ptr.sv
// -----------------------------------------------------------------------------
// fifo_mem_ptr
// Circular byte store with read/write pointers and an occupancy counter.
// Ports:
//   clk, reset (async, active-high)
//   wr_en, wr_data : write wr_data at the write pointer
//   rd_en          : advance the read pointer (caller guarantees !empty)
//   rd_data        : entry at the read pointer (head), combinational
//   count          : occupancy 0..DEPTH, registered
//   full, empty    : combinational decode of count
// -----------------------------------------------------------------------------
module fifo_mem_ptr
  import uart_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W     = BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH. When full, a write and read in the same
  // cycle hit the same slot: the old head is read combinationally before the
  // edge and replaced by the new byte at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Elastic byte buffer between the UART receiver and transmitter in the echo
// path. Each rising edge of the (registered) receiver ready level pushes one
// byte and pulses rx_clear; a drain FSM feeds queued bytes to the transmitter
// through the send/busy handshake.
// Ports:
//   clk, reset          : clock, async active-high reset
//   rx_data, rx_ready   : receiver byte and data-ready level
//   rx_clear            : one-cycle acknowledge to the receiver
//   tx_data, tx_send    : byte and one-cycle send pulse to the transmitter
//   tx_busy             : transmitter busy level
//   count, empty, full  : occupancy (registered) and its decodes (combinational)
//   overflow            : sticky, set when a byte is dropped
//   drop_count          : saturating dropped-byte counter, only when
//                         UART_FIFO_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
module uart_byte_fifo
  import uart_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_ready,
  output logic                 rx_clear,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [DEPTH_LOG2:0]  count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
`ifdef UART_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  localparam int              TO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  drain_state_t      state;
  logic [TO_W-1:0]   to_cnt;
  logic              rdy_p0;
  logic              rdy_p1;
  logic              push_req;
  logic              pop;
  logic              accept;
  logic              drop;
  logic [BYTE_W-1:0] head;

`ifdef UART_FIFO_DROP_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Pop is decided here so the capture side can see a same-cycle pop and
  // accept a byte into an otherwise full FIFO.
  assign pop      = (state == IDLE) && !empty && !tx_busy;
  assign push_req = rdy_p0 && !rdy_p1;
  assign accept   = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  fifo_mem_ptr #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (BYTE_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // ---- capture stage: p0 = registered rx_ready, p1 = its previous value ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_p0   <= 1'b0;
      rdy_p1   <= 1'b0;
      rx_clear <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rdy_p0   <= rx_ready;
      rdy_p1   <= rdy_p0;
      rx_clear <= push_req;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef UART_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'h00;
    end else if (drop) begin
      drop_count <= sat_inc8(drop_count);
    end
  end
`endif

  // ---- drain stage: head byte to transmitter ----
  // tx_send is registered and raised on the IDLE->SEND transition, so it is
  // high exactly during the SEND cycle. A transmitter that never raises busy
  // is abandoned after BUSY_TIMEOUT cycles in WAIT_HI; the byte is treated
  // as sent and never retried.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
      to_cnt  <= '0;
    end else begin
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= head;
            tx_send <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_fifo
// Directed bench for uart_byte_fifo with a byte scoreboard and a simple
// transmitter busy model. Honours UART_FIFO_DROP_CNT_EN for drop_count.
// -----------------------------------------------------------------------------
module tb_uart_byte_fifo;

  localparam int DL2 = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_ready = 1'b0;
  logic           rx_clear;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic [DL2:0]   count;
  logic           empty;
  logic           full;
  logic           overflow;
`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0]     drop_count;
`endif

  int         tests = 0;
  int         fails = 0;
  int         clear_cnt = 0;
  int         send_cnt = 0;
  logic [7:0] sb [$];
  logic [8:0] exp_v;

  logic busy_hold = 1'b0;
  logic busy_never = 1'b0;
  logic busy_m = 1'b0;
  int   busy_len = 3;
  int   busy_left = 0;

  assign tx_busy = busy_m | busy_hold;

  always #5 clk = ~clk;

  uart_byte_fifo #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_clear   (rx_clear),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow)
`ifdef UART_FIFO_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every send must match the oldest outstanding byte; bit 8 marks presence.
  always @(posedge clk) begin
    #1;
    if (rx_clear === 1'b1) clear_cnt++;
    if (tx_send === 1'b1) begin
      send_cnt++;
      exp_v = (sb.size() > 0) ? {1'b1, sb.pop_front()} : 9'h000;
      chk("tx_byte", {23'd0, 1'b1, tx_data}, {23'd0, exp_v});
    end
  end

  // Transmitter: busy rises the cycle after a send pulse, for busy_len cycles.
  always @(posedge clk) begin
    #2;
    if (reset) busy_left = 0;
    else if (tx_send === 1'b1 && !busy_never) busy_left = busy_len;
    busy_m = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    rx_data  = b;
    rx_ready = 1'b1;
    if (acc) sb.push_back(b);
    tick(2);
    rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic drain(input int bound, input string tag);
    int n = 0;
    while ((sb.size() != 0 || count != 0) && n < bound) begin
      tick(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int s0;
    int c0;
    int n;

    // Reset values
    tick(2);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_rx_clear", rx_clear, 0);
    chk("rst_tx_data", tx_data, 8'h00);
`ifdef UART_FIFO_DROP_CNT_EN
    chk("rst_drop_count", drop_count, 0);
`endif
    reset = 1'b0;
    tick(2);

    // Single byte: latency 3 edges from the rx_ready rise
    busy_len = 20;
    rx_data  = 8'h41;
    rx_ready = 1'b1;
    sb.push_back(8'h41);
    tick(1);
    chk("lat_e0_send", tx_send, 0);
    tick(1);
    chk("lat_rx_clear", rx_clear, 1);
    chk("lat_e1_send", tx_send, 0);
    tick(1);
    chk("lat_e2_send", tx_send, 1);
    chk("lat_tx_data", tx_data, 8'h41);
    chk("lat_rx_clear_off", rx_clear, 0);
    tick(7);
    rx_ready = 1'b0;
    tick(30);
    chk("single_count", count, 0);
    chk("single_sends", send_cnt, 1);
    chk("single_clears", clear_cnt, 1);

    // Burst ordering while the transmitter is busy
    busy_len  = 4;
    busy_hold = 1'b1;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    chk("burst_count", count, 5);
    chk("burst_no_send", send_cnt, 1);
    busy_hold = 1'b0;
    drain(300, "burst_drain");
    tick(5);
    chk("burst_sends", send_cnt, 6);
    chk("burst_empty", empty, 1);

    // Overflow: 17 pushes with busy stuck high
    c0 = clear_cnt;
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
    push(8'hEE, 1'b0);
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_empty", empty, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_clears", clear_cnt - c0, 17);
`ifdef UART_FIFO_DROP_CNT_EN
    chk("ovf_drop_count", drop_count, 1);
`endif
    busy_hold = 1'b0;
    drain(600, "ovf_drain");
    tick(5);
    chk("ovf_sends", send_cnt, 22);
    chk("ovf_sticky", overflow, 1);

    reset = 1'b1;
    tick(1);
    sb.delete();
    chk("rst2_overflow", overflow, 0);
    reset = 1'b0;
    tick(2);

    // Simultaneous push and pop on a full FIFO
    s0 = send_cnt;
    busy_hold = 1'b1;
    busy_len  = 3;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    chk("sim_pre_count", count, 16);
    rx_data  = 8'h20;
    rx_ready = 1'b1;
    sb.push_back(8'h20);
    tick(1);
    busy_hold = 1'b0;
    tick(1);
    chk("sim_count", count, 16);
    chk("sim_tx_send", tx_send, 1);
    chk("sim_overflow", overflow, 0);
    rx_ready = 1'b0;
    drain(600, "sim_drain");
    tick(5);
    chk("sim_sends", send_cnt - s0, 17);
    chk("sim_overflow_end", overflow, 0);

    // Busy timeout: busy never rises after a send
    s0 = send_cnt;
    busy_hold = 1'b1;
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    busy_never = 1'b1;
    busy_hold  = 1'b0;
    n = 0;
    while (tx_send !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("to_first_send", tx_send, 1);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (tx_send !== 1'b1 && n < 200);
    chk("to_gap", n, 66);
    busy_never = 1'b0;
    push(8'h77, 1'b1);
    drain(400, "to_drain");
    tick(10);
    chk("to_sends", send_cnt - s0, 3);
    chk("to_count", count, 0);

    // Reset mid-operation during WAIT_LO with three bytes queued
    busy_len = 40;
    s0 = send_cnt;
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    push(8'hA3, 1'b1);
    push(8'hA4, 1'b1);
    chk("mid_pre_count", count, 3);
    chk("mid_pre_busy", tx_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_tx_send", tx_send, 0);
    chk("mid_tx_data", tx_data, 8'h00);
    chk("mid_rx_clear", rx_clear, 0);
    chk("mid_overflow", overflow, 0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    busy_len = 3;
    tick(40);
    chk("mid_no_send", send_cnt - s0, 1);
    push(8'h5A, 1'b1);
    drain(100, "mid_new_drain");
    tick(5);
    chk("mid_new_send", send_cnt - s0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
